uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Transmit-side buffer and sequencer that sits directly upstream of the UART transmitter.
- Accepts bytes from a producer through a write-enable interface and stores them in a circular FIFO.
- Pops one byte at a time, presents it on tx_data and pulses tx_start. It then waits for the transmitter's tx_done_tick before issuing the next byte.

Parameters:
DATA_WIDTH, 8, width of each byte/word (matches transmitter tx_data)
ADDR_WIDTH, 4, FIFO address bits; DEPTH = 2**ADDR_WIDTH entries (16 default)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
wr_en  in  1  producer write request
wr_data  in  DATA_WIDTH  byte to enqueue
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
count  out  ADDR_WIDTH+1  current FIFO occupancy
overflow  out  1  one-cycle pulse: write attempted while full, byte dropped
tx_start  out  1  one-cycle pulse to transmitter: tx_data valid, begin frame
tx_data  out  DATA_WIDTH  byte for transmitter; held stable from tx_start until next pop
tx_done_tick  in  1  one-cycle pulse from transmitter: frame (incl. stop bit) complete
busy  out  1  sequencer not in IDLE (a byte is being handed off or transmitted)

Behaviour:
- Storage: DEPTH x DATA_WIDTH array (not reset), wr_ptr/rd_ptr ADDR_WIDTH bits wrap modulo DEPTH naturally, count register ADDR_WIDTH+1 bits.
- full = (count == DEPTH), empty = (count == 0), both decoded from registered count (no combinational path from wr_en).
- Push accepted iff wr_en && !full (full as of current cycle); mem[wr_ptr] <= wr_data, wr_ptr++.
- wr_en && full: nothing stored, overflow = 1 for the following cycle only. This applies even if a pop occurs in the same cycle; no write-through when full.
- Push and pop same cycle: count unchanged, both pointers advance.
- Sequencer FSM, 3 states:
  - IDLE: busy=0. If !empty, pop: tx_data <= mem[rd_ptr], rd_ptr++, count--, go START.
  - START: tx_start=1 (Moore, exactly one cycle), go WAIT.
  - WAIT: hold tx_data. On tx_done_tick go IDLE.
- tx_done_tick in IDLE or START is ignored.
- busy = (state != IDLE).
- Latency: push at edge N into empty FIFO with FSM in IDLE → pop at edge N+1 → tx_start high during cycle after edge N+2 (2 cycles write-to-start).
- Back-to-back frames: tx_done_tick at edge M with FIFO non-empty → IDLE at M, pop at M+1, tx_start during cycle after M+2. This is a 2-cycle gap, within the transmitter's idle acceptance window.
- Reset (reset==0 at an edge): state=IDLE, wr_ptr=rd_ptr=0, count=0, tx_data=0, tx_start=0, overflow=0. Resulting outputs are empty=1, full=0, busy=0.
- Reset mid-operation discards all queued bytes and abandons WAIT immediately, with no wait for tx_done_tick. The transmitter is reset from the same system reset.
- count never exceeds DEPTH nor underflows; a pop only occurs when !empty.

Test Plan:
1. Reset low 2 cycles then high; write 0x55 once → count 0→1→0, tx_start single-cycle pulse 2 cycles after write edge with tx_data=0x55, busy=1 until tx_done_tick pulse then 0, empty=1.
2. With tx_done_tick held low, write 0x00..0x11 (18 bytes) on consecutive cycles → tx_data=0x00 (one tx_start), 0x01..0x10 stored, count=16, full=1, write of 0x11 dropped with a single overflow pulse.
3. From scenario 2, pulse tx_done_tick 17 times, each ≥3 cycles after the preceding tx_start → tx_data sequence 0x01..0x10 in order with exactly one tx_start per done tick. The byte on tx_data when each done tick arrives is the one started before it. Final state: empty=1, busy=0, no extra tx_start.
4. Full FIFO, FSM in IDLE popping, wr_en=1 same cycle with 0xAA → pop occurs, 0xAA dropped, overflow=1, count=15.
5. Pulse tx_done_tick while empty/IDLE, and while in START → no state change, no pop, no tx_start.
6. 5 bytes queued, FSM in WAIT, assert reset one cycle → next cycle count=0, empty=1, busy=0, tx_data=0. After release, no tx_start occurs until a new write.
7. Connected to the transmitter with a 16x baud tick: write "A" (0x41) → tx line shows start bit, 1,0,0,0,0,0,1,0 (LSB first), stop bit; busy falls after tx_done_tick.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and hand-off sequencer in front of a UART transmitter.
// Bytes are queued by the producer and issued one frame at a time, gated by tx_done_tick.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_done_tick,
  output logic                  busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;
  state_t                r_state;
  state_t                w_state_next;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  // Flags come from the registered count only, so wr_en never reaches them combinationally.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = wr_en && !w_full;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: w_state_next = S_WAIT;
      S_WAIT: begin
        if (tx_done_tick) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_overflow <= wr_en && w_full;
      r_tx_start <= (r_state == S_START);
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(1);
        r_tx_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: scoreboard of queued bytes checked at every tx_start,
// plus occupancy/flag/pulse checks and a behavioural 16x-baud transmitter for the line frame.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done_tick;
  logic       busy;

  int         checks   = 0;
  int         failures = 0;
  int         n_starts = 0;
  logic [7:0] sb[$];
  logic [7:0] last_exp = 8'h00;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each tx_start must deliver the oldest byte the bench expects to have been accepted.
  always @(negedge clk) begin
    if (reset === 1'b1 && tx_start === 1'b1) begin
      n_starts++;
      chk("start_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        last_exp = sb.pop_front();
        chk("tx_data", 32'(tx_data), 32'(last_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) sb.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic done();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
  endtask

  task automatic wait_start();
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (tx_start) seen = 1'b1;
    end
    chk("start_seen", 32'(seen), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!busy && empty) break;
      done();
      repeat (4) tick();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_sb", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int         s0;
    logic [9:0] frame;
    logic [9:0] exp_frame;
    logic [7:0] a_byte;

    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_done_tick = 1'b0;

    // 1: reset state and a single byte
    repeat (2) tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b1;
    tick();
    wr(8'h55, 1'b1);
    chk("s1_count1", 32'(count), 32'd1);
    chk("s1_start_n", 32'(tx_start), 32'd0);
    tick();
    chk("s1_count0", 32'(count), 32'd0);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_start_n1", 32'(tx_start), 32'd0);
    tick();
    chk("s1_start", 32'(tx_start), 32'd1);
    chk("s1_data", 32'(tx_data), 32'h55);
    tick();
    chk("s1_start_pulse", 32'(tx_start), 32'd0);
    repeat (3) tick();
    chk("s1_busy_wait", 32'(busy), 32'd1);
    done();
    chk("s1_idle", 32'(busy), 32'd0);
    chk("s1_empty", 32'(empty), 32'd1);

    // 2: fill to full, one overflowing write
    s0 = n_starts;
    for (int i = 0; i < 18; i++) begin
      wr(8'(i), i < 17);
      if (i < 17) chk("s2_no_ovf", 32'(overflow), 32'd0);
    end
    chk("s2_ovf", 32'(overflow), 32'd1);
    chk("s2_count", 32'(count), 32'd16);
    chk("s2_full", 32'(full), 32'd1);
    tick();
    chk("s2_ovf_pulse", 32'(overflow), 32'd0);
    chk("s2_starts", 32'(n_starts - s0), 32'd1);

    // 3: drain with spaced done ticks, one frame per tick
    for (int i = 0; i < 17; i++) begin
      s0 = n_starts;
      chk("s3_data_at_done", 32'(tx_data), 32'(last_exp));
      done();
      repeat (4) tick();
      chk("s3_one_start", 32'(n_starts - s0), (i < 16) ? 32'd1 : 32'd0);
    end
    chk("s3_empty", 32'(empty), 32'd1);
    chk("s3_idle", 32'(busy), 32'd0);
    chk("s3_sb", 32'(sb.size()), 32'd0);

    // 4: write while full on the same cycle as a pop
    wr(8'h20, 1'b1);
    for (int i = 1; i <= 16; i++) wr(8'(8'h20 + i), 1'b1);
    repeat (3) tick();
    chk("s4_full", 32'(full), 32'd1);
    done();
    wr(8'hAA, 1'b0);
    chk("s4_ovf", 32'(overflow), 32'd1);
    chk("s4_count", 32'(count), 32'd15);
    chk("s4_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    drain();

    // 5: done tick in IDLE and in START is ignored
    s0 = n_starts;
    done();
    chk("s5_idle_busy", 32'(busy), 32'd0);
    chk("s5_idle_start", 32'(tx_start), 32'd0);
    tick();
    chk("s5_idle_start2", 32'(tx_start), 32'd0);
    chk("s5_idle_none", 32'(n_starts - s0), 32'd0);
    wr(8'h5A, 1'b1);
    tick();
    done();
    chk("s5_start_pulse", 32'(tx_start), 32'd1);
    repeat (2) tick();
    chk("s5_still_wait", 32'(busy), 32'd1);
    chk("s5_one_start", 32'(n_starts - s0), 32'd1);
    drain();

    // 6: reset in WAIT with bytes queued
    for (int i = 0; i < 6; i++) wr(8'(8'h61 + i), 1'b1);
    repeat (3) tick();
    chk("s6_count5", 32'(count), 32'd5);
    chk("s6_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sb.delete();
    chk("s6_count", 32'(count), 32'd0);
    chk("s6_empty", 32'(empty), 32'd1);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_txdata", 32'(tx_data), 32'd0);
    s0 = n_starts;
    repeat (10) tick();
    chk("s6_no_start", 32'(n_starts - s0), 32'd0);
    wr(8'h77, 1'b1);
    repeat (3) tick();
    chk("s6_restart", 32'(n_starts - s0), 32'd1);
    drain();

    // 7: behavioural transmitter, baud tick every 2 clocks, 16 ticks per bit
    a_byte    = 8'h41;
    exp_frame = {1'b1, a_byte, 1'b0};
    wr(a_byte, 1'b1);
    wait_start();
    frame = {1'b1, tx_data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int t = 0; t < 16; t++) begin
        repeat (2) tick();
        if (t == 7) chk($sformatf("s7_bit%0d", b), 32'(frame[b]), 32'(exp_frame[b]));
      end
      if (b == 9) chk("s7_hold", 32'(tx_data), 32'h41);
    end
    chk("s7_busy_frame", 32'(busy), 32'd1);
    done();
    chk("s7_busy_fall", 32'(busy), 32'd0);
    chk("s7_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
